// File: rtl/thread_switch_controller_pkg.sv
// ---------------------------------------------------------------------------
// thread_switch_controller_pkg
//   Shared definitions for the coarse-grained multithreading controller:
//   thread count, thread-id width and the controller state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package thread_switch_controller_pkg;

  // Two threads: the d-cache tags its address MSB with thread_id.
  localparam int NUM_THREADS = 2;
  localparam int TID_W       = $clog2(NUM_THREADS);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    IDLE   = 2'd3
  } tsc_state_t;

endpackage : thread_switch_controller_pkg

// File: rtl/thread_switch_controller_rr_next_thread.sv
// ---------------------------------------------------------------------------
// rr_next_thread
//   Combinational round-robin picker. Returns the first runnable thread after
//   the current one (wrapping), never the current thread itself.
// Ports:
//   i_mask       in  N  runnable mask
//   i_cur        in  W  current thread id
//   o_next       out W  next thread id (equals i_cur when no other is ready)
//   o_other_rdy  out 1  some runnable thread other than i_cur exists
// ---------------------------------------------------------------------------
module rr_next_thread
  import thread_switch_controller_pkg::*;
#(
  parameter int N = NUM_THREADS,
  parameter int W = TID_W
) (
  input  logic [N-1:0] i_mask,
  input  logic [W-1:0] i_cur,
  output logic [W-1:0] o_next,
  output logic         o_other_rdy
);

  logic [W-1:0] w_idx;
  logic         w_hit;

  // Scan offsets from farthest to nearest so the nearest runnable thread
  // after i_cur is the last one written and therefore wins. N is a power
  // of two, so the W-bit add wraps naturally.
  always_comb begin
    o_next      = i_cur;
    o_other_rdy = 1'b0;
    w_idx       = i_cur;
    w_hit       = 1'b0;
    for (int k = N - 1; k >= 1; k--) begin
      w_idx       = i_cur + W'(k);
      w_hit       = i_mask[w_idx];
      o_next      = w_hit ? w_idx : o_next;
      o_other_rdy = o_other_rdy | w_hit;
    end
  end

endmodule : rr_next_thread

// File: rtl/thread_switch_controller.sv
// ---------------------------------------------------------------------------
// thread_switch_controller
//   Switch-on-event multithreading control. One thread owns the pipeline;
//   a switch happens on halt, on a long mem-stage stall or on quantum expiry.
//   The outgoing thread's resume PC is saved, the pipeline is flushed, the
//   controller waits for the mem stage to go idle, then changes thread_id and
//   redirects fetch to the incoming thread's saved PC.
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   i_mem_done        0 = mem stage stalled this cycle
//   i_resume_pc       PC of oldest unretired instruction of current thread
//   i_thread_halt     1-cycle pulse: current thread executed halt
//   o_tc              thread_id driven to the whole pipeline
//   o_flush           1-cycle pulse: squash IF..EX
//   o_redirect_valid  1-cycle pulse: fetch loads o_redirect_pc
//   o_redirect_pc     restore PC of incoming thread
//   o_runnable        bit t = thread t not halted
//   o_all_done        no thread runnable (sticky until reset)
// ---------------------------------------------------------------------------
module thread_switch_controller
  import thread_switch_controller_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    QUANTUM     = 64,
  parameter int                    MISS_THRESH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = {ADDR_WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_mem_done,
  input  logic [ADDR_WIDTH-1:0]  i_resume_pc,
  input  logic                   i_thread_halt,
  output logic [TID_W-1:0]       o_tc,
  output logic                   o_flush,
  output logic                   o_redirect_valid,
  output logic [ADDR_WIDTH-1:0]  o_redirect_pc,
  output logic [NUM_THREADS-1:0] o_runnable,
  output logic                   o_all_done
);

  localparam int QW = $clog2(QUANTUM);
  localparam int SW = $clog2(MISS_THRESH + 1);
  localparam logic [QW-1:0] Q_LAST = QW'(QUANTUM - 1);
  localparam logic [SW-1:0] S_TRIG = SW'(MISS_THRESH - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(MISS_THRESH);

  tsc_state_t             r_state;
  logic [QW-1:0]          r_qcnt;
  logic [SW-1:0]          r_scnt;
  logic [TID_W-1:0]       r_tid;
  logic [NUM_THREADS-1:0] r_runnable;
  logic                   r_flush;
  logic                   r_redirect_valid;
  logic [ADDR_WIDTH-1:0]  r_redirect_pc;
  logic                   r_all_done;
  logic [ADDR_WIDTH-1:0]  r_saved_pc [NUM_THREADS];

  tsc_state_t             w_state_nxt;
  logic [QW-1:0]          w_qcnt_nxt;
  logic [SW-1:0]          w_scnt_nxt;
  logic [TID_W-1:0]       w_tid_nxt;
  logic [NUM_THREADS-1:0] w_runnable_nxt;
  logic                   w_flush_nxt;
  logic                   w_redirect_valid_nxt;
  logic [ADDR_WIDTH-1:0]  w_redirect_pc_nxt;
  logic                   w_all_done_nxt;
  logic                   w_save_en;
  logic [TID_W-1:0]       w_next_tid;
  logic                   w_other_rdy;
  logic                   w_quant_trig;
  logic                   w_miss_trig;

  rr_next_thread #(
    .N (NUM_THREADS),
    .W (TID_W)
  ) u_rr_next_thread (
    .i_mask      (r_runnable),
    .i_cur       (r_tid),
    .o_next      (w_next_tid),
    .o_other_rdy (w_other_rdy)
  );

  // Miss trigger fires on the MISS_THRESH-th consecutive stalled cycle.
  assign w_quant_trig = (r_qcnt == Q_LAST);
  assign w_miss_trig  = !i_mem_done && (r_scnt == S_TRIG);

  // Next-state and next-output logic for the switch FSM.
  always_comb begin
    w_state_nxt          = r_state;
    w_qcnt_nxt           = r_qcnt;
    w_scnt_nxt           = r_scnt;
    w_tid_nxt            = r_tid;
    w_runnable_nxt       = r_runnable;
    w_flush_nxt          = 1'b0;
    w_redirect_valid_nxt = 1'b0;
    w_redirect_pc_nxt    = r_redirect_pc;
    w_all_done_nxt       = r_all_done;
    w_save_en            = 1'b0;
    case (r_state)
      RUN: begin
        if (i_thread_halt) begin
          // A halted thread never resumes, so its PC is not saved.
          w_runnable_nxt[r_tid] = 1'b0;
          if (w_other_rdy) begin
            w_flush_nxt = 1'b1;
            w_state_nxt = DRAIN;
          end else begin
            w_all_done_nxt = 1'b1;
            w_state_nxt    = IDLE;
          end
        end else if (w_miss_trig || w_quant_trig) begin
          if (w_other_rdy) begin
            w_save_en   = 1'b1;
            w_flush_nxt = 1'b1;
            w_state_nxt = DRAIN;
          end else begin
            // Nobody to switch to: start a fresh quantum in place.
            w_qcnt_nxt = {QW{1'b0}};
            w_scnt_nxt = {SW{1'b0}};
          end
        end else begin
          w_qcnt_nxt = w_quant_trig ? r_qcnt : r_qcnt + 1'b1;
          if (i_mem_done) begin
            w_scnt_nxt = {SW{1'b0}};
          end else begin
            w_scnt_nxt = (r_scnt == S_MAX) ? r_scnt : r_scnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Outstanding d-cache access is tagged with the old thread_id, so
        // thread_id may only change once the mem stage is idle.
        if (i_mem_done) begin
          w_tid_nxt            = w_next_tid;
          w_redirect_pc_nxt    = r_saved_pc[w_next_tid];
          w_redirect_valid_nxt = 1'b1;
          w_state_nxt          = SWITCH;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      SWITCH: begin
        w_qcnt_nxt  = {QW{1'b0}};
        w_scnt_nxt  = {SW{1'b0}};
        w_state_nxt = RUN;
      end
      IDLE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_qcnt_nxt  = {QW{1'b0}};
        w_scnt_nxt  = {SW{1'b0}};
        w_state_nxt = RUN;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= RUN;
      r_qcnt           <= {QW{1'b0}};
      r_scnt           <= {SW{1'b0}};
      r_tid            <= {TID_W{1'b0}};
      r_runnable       <= {NUM_THREADS{1'b1}};
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= {ADDR_WIDTH{1'b0}};
      r_all_done       <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_qcnt           <= w_qcnt_nxt;
      r_scnt           <= w_scnt_nxt;
      r_tid            <= w_tid_nxt;
      r_runnable       <= w_runnable_nxt;
      r_flush          <= w_flush_nxt;
      r_redirect_valid <= w_redirect_valid_nxt;
      r_redirect_pc    <= w_redirect_pc_nxt;
      r_all_done       <= w_all_done_nxt;
    end
  end

  // Per-thread resume PC flops, written when a thread is switched out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_saved_pc[i] <= RESET_PC;
      end
    end else if (w_save_en) begin
      r_saved_pc[r_tid] <= i_resume_pc;
    end
  end

  assign o_tc             = r_tid;
  assign o_flush          = r_flush;
  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
  assign o_runnable       = r_runnable;
  assign o_all_done       = r_all_done;

endmodule : thread_switch_controller

// File: tb/tb_thread_switch_controller.sv
// ---------------------------------------------------------------------------
// tb_thread_switch_controller
//   Directed scenarios plus randomized traffic, every cycle compared against
//   an event-level reference model of the switching rules.
// ---------------------------------------------------------------------------
module tb_thread_switch_controller;

  localparam int          AW          = 32;
  localparam int          NT          = 2;
  localparam int          QUANTUM     = 8;
  localparam int          MISS_THRESH = 4;
  localparam logic [31:0] RPC         = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_done;
  logic [AW-1:0] resume_pc;
  logic          thread_halt;
  logic          tc;
  logic          flush;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [NT-1:0] runnable;
  logic          all_done;

  always #5 clk = ~clk;

  thread_switch_controller #(
    .ADDR_WIDTH  (AW),
    .QUANTUM     (QUANTUM),
    .MISS_THRESH (MISS_THRESH),
    .RESET_PC    (RPC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_mem_done       (mem_done),
    .i_resume_pc      (resume_pc),
    .i_thread_halt    (thread_halt),
    .o_tc             (tc),
    .o_flush          (flush),
    .o_redirect_valid (redirect_valid),
    .o_redirect_pc    (redirect_pc),
    .o_runnable       (runnable),
    .o_all_done       (all_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the pipeline, how long it has run in this
  // quantum, how many stalls in a row, and where each thread resumes.
  int          m_tid;
  bit          m_alive [NT];
  int          m_age;
  int          m_stalls;
  logic [31:0] m_saved [NT];
  bit          m_waiting_mem;
  bit          m_restarting;
  bit          m_finished;
  bit          e_flush;
  bit          e_rv;
  logic [31:0] e_rpc;
  bit          e_done;

  function automatic bit others_alive();
    for (int k = 1; k < NT; k++) begin
      if (m_alive[(m_tid + k) % NT]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int pick_next();
    for (int k = 1; k < NT; k++) begin
      if (m_alive[(m_tid + k) % NT]) return (m_tid + k) % NT;
    end
    return m_tid;
  endfunction

  task automatic model_step(input bit r, input bit m, input bit h, input logic [31:0] pc);
    bit other, quant, miss;
    if (r) begin
      m_tid = 0; m_age = 0; m_stalls = 0;
      for (int t = 0; t < NT; t++) begin m_alive[t] = 1'b1; m_saved[t] = RPC; end
      m_waiting_mem = 1'b0; m_restarting = 1'b0; m_finished = 1'b0;
      e_flush = 1'b0; e_rv = 1'b0; e_rpc = 32'h0; e_done = 1'b0;
      return;
    end
    e_flush = 1'b0;
    e_rv    = 1'b0;
    if (m_finished) begin
      // nothing ever happens until reset
    end else if (m_restarting) begin
      m_restarting = 1'b0; m_age = 0; m_stalls = 0;
    end else if (m_waiting_mem) begin
      if (m) begin
        m_tid = pick_next();
        e_rpc = m_saved[m_tid];
        e_rv  = 1'b1;
        m_waiting_mem = 1'b0;
        m_restarting  = 1'b1;
      end
    end else begin
      other = others_alive();
      quant = (m_age + 1 >= QUANTUM);
      miss  = !m && (m_stalls + 1 >= MISS_THRESH);
      if (h) begin
        m_alive[m_tid] = 1'b0;
        if (other) begin e_flush = 1'b1; m_waiting_mem = 1'b1; end
        else begin m_finished = 1'b1; e_done = 1'b1; end
      end else if (quant || miss) begin
        if (other) begin
          m_saved[m_tid] = pc; e_flush = 1'b1; m_waiting_mem = 1'b1;
        end else begin
          m_age = 0; m_stalls = 0;
        end
      end else begin
        m_age++;
        m_stalls = m ? 0 : m_stalls + 1;
      end
    end
  endtask

  function automatic logic [NT-1:0] exp_runnable();
    logic [NT-1:0] v;
    for (int t = 0; t < NT; t++) v[t] = m_alive[t];
    return v;
  endfunction

  // One clock: drive inputs, advance model at the edge, compare #1 later.
  task automatic cyc(input bit r, input bit m, input bit h, input logic [31:0] pc);
    rst = r; mem_done = m; thread_halt = h; resume_pc = pc;
    @(posedge clk);
    model_step(r, m, h, pc);
    #1;
    check("tid",      64'(tc),             64'(m_tid));
    check("flush",    64'(flush),          64'(e_flush));
    check("redir_v",  64'(redirect_valid), 64'(e_rv));
    check("redir_pc", 64'(redirect_pc),    64'(e_rpc));
    check("runnable", 64'(runnable),       64'(exp_runnable()));
    check("all_done", 64'(all_done),       64'(e_done));
  endtask

  // Run until the given thread is executing (not mid-switch), bounded.
  task automatic run_to_tid(input int t);
    int n;
    n = 0;
    while (!(m_tid == t && !m_waiting_mem && !m_restarting && !m_finished)) begin
      if (n >= 200) begin
        n_checks++; n_fail++;
        $display("FAIL wait_tid: thread %0d never running, got tid %0d", t, m_tid);
        return;
      end
      cyc(1'b0, 1'b1, 1'b0, 32'h0000_0200 + 32'(n));
      n++;
    end
  endtask

  initial begin
    int burst;
    bit r, m, h;
    rst = 1'b1; mem_done = 1'b1; thread_halt = 1'b0; resume_pc = 32'h0;

    // Reset state
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);

    // Quantum expiry round trip with resume PC 0x40
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0000_0040);

    // Long stall: flush after the 4th stall, thread held until mem idle
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0000_0080);
    cyc(1'b0, 1'b1, 1'b0, 32'h0000_0080);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0000_0084);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0000_0088);

    // Halt thread 1, then thread 0 -> idle
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    run_to_tid(1);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0300);
    run_to_tid(0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0000_0304);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0308);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // Single runnable thread with stall bursts: never switches
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    run_to_tid(1);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0400);
    run_to_tid(0);
    for (int i = 0; i < 3 * QUANTUM + 12; i++) cyc(1'b0, (i % 9) < 3, 1'b0, 32'h0000_0500);

    // Halt coinciding with quantum expiry
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    while (m_age != QUANTUM - 1) cyc(1'b0, 1'b1, 1'b0, 32'h0000_0600);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0666);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0000_0700);
    check("saved_pc_halted", 64'(m_saved[0]), 64'(RPC));

    // Reset during DRAIN aborts the switch
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0000_0800);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0000_0900);

    // Randomized traffic
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 7);
      m = (burst == 0);
      if (burst > 0) burst--;
      h = ($urandom_range(0, 79) == 0);
      r = ($urandom_range(0, 299) == 0) || (m_finished && $urandom_range(0, 7) == 0);
      cyc(r, m, h, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_thread_switch_controller
